// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: receiving end of the 4-bit character-LCD bus.
// It synchronizes the LCDE/LCDRS/LCDRW/LCDDAT pins and detects falling LCDE strobes.
// It reassembles the 4-bit init nibbles and the HI/LO nibble pairs into bytes.
// It executes the clear, home and set-address commands and keeps a 2x16 character buffer.
// It also models busy timing and the nibble read-back path.
module lcd_nibble_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYC    = 40,
  parameter int CLEAR_CYC   = 1600
) (
  input  logic       CCLK,
  input  logic       RSTN,
  input  logic       LCDE,
  input  logic       LCDRS,
  input  logic       LCDRW,
  input  logic [3:0] LCDDAT,
  output logic [3:0] LCDQ,
  output logic       MODE4,
  output logic       BUSY,
  output logic       ERR,
  output logic       BYTE_VLD,
  output logic       BYTE_RS,
  output logic [7:0] BYTE,
  input  logic [4:0] RD_IDX,
  output logic [7:0] RD_CHAR
);

  // Synchronizer depth never drops below two flops.
  localparam int SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int BMAX = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
  localparam int CW   = $clog2(BMAX + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYC);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYC);

  typedef enum logic [1:0] {
    ST_INIT8 = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2
  } state_t;

  // Address counter increment with the two-line wrap 0x0F -> 0x40 -> ... -> 0x4F -> 0x00.
  function automatic logic [6:0] ac_inc(input logic [6:0] a);
    logic [6:0] r;
    if (a[3:0] == 4'hF) begin
      r = a[6] ? 7'h00 : 7'h40;
    end else begin
      r = a + 7'd1;
    end
    return r;
  endfunction

  logic [6:0]         in_s;
  logic [SS-1:0][6:0] sync_r;
  logic [6:0]         tap_r;
  logic               stb_s;
  logic               wr_stb_s;
  logic               rd_stb_s;
  logic               tap_rs_s;
  logic               tap_rw_s;
  logic [3:0]         tap_dat_s;

  state_t     state_r, state_nx_s;
  logic       mode4_r, mode4_nx_s;
  logic       err_r, err_nx_s;
  logic [6:0] ac_r, ac_nx_s;
  logic [3:0] hi_nib_r, hi_nib_nx_s;
  logic       hi_rs_r, hi_rs_nx_s;
  logic       rd_lo_r, rd_lo_nx_s;
  logic [3:0] q_r, q_nx_s;
  logic       vld_r, vld_nx_s;
  logic [7:0] byte_r, byte_nx_s;
  logic       byte_rs_r, byte_rs_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic       busy_r;
  logic       busy_ld_s;
  logic [CW-1:0] busy_val_s;
  logic       mem_we_s;
  logic       mem_clr_s;
  logic [7:0] asm_byte_s;
  logic [4:0] idx_s;
  logic [7:0] cur_char_s;
  logic [7:0] mem_r [32];

  assign in_s       = {LCDE, LCDRS, LCDRW, LCDDAT};
  assign stb_s      = tap_r[6] & ~sync_r[SS-1][6];
  assign tap_rs_s   = tap_r[5];
  assign tap_rw_s   = tap_r[4];
  assign tap_dat_s  = tap_r[3:0];
  assign wr_stb_s   = stb_s & ~tap_rw_s;
  assign rd_stb_s   = stb_s & tap_rw_s;
  assign asm_byte_s = {hi_nib_r, tap_dat_s};
  assign idx_s      = {ac_r[6], ac_r[3:0]};
  assign cur_char_s = mem_r[idx_s];

  // Pin synchronizer chain plus one delayed copy that holds the E=1 sample's fields.
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_r <= '0;
      tap_r  <= 7'h00;
    end else begin
      sync_r <= {sync_r[SS-2:0], in_s};
      tap_r  <= sync_r[SS-1];
    end
  end

  // Nibble assembly, command/data execution and read-back decisions.
  always_comb begin
    state_nx_s   = state_r;
    mode4_nx_s   = mode4_r;
    err_nx_s     = err_r;
    ac_nx_s      = ac_r;
    hi_nib_nx_s  = hi_nib_r;
    hi_rs_nx_s   = hi_rs_r;
    rd_lo_nx_s   = rd_lo_r;
    q_nx_s       = q_r;
    vld_nx_s     = 1'b0;
    byte_nx_s    = byte_r;
    byte_rs_nx_s = byte_rs_r;
    busy_ld_s    = 1'b0;
    busy_val_s   = BUSY_LD;
    mem_we_s     = 1'b0;
    mem_clr_s    = 1'b0;
    if (wr_stb_s) begin
      if (busy_r) begin
        // Writer ignored the busy flag: flag it and drop the nibble.
        err_nx_s = 1'b1;
      end else begin
        case (state_r)
          ST_INIT8: begin
            if (tap_dat_s == 4'h3) begin
              busy_ld_s = 1'b1;
            end else if ((tap_dat_s == 4'h2) && !tap_rs_s) begin
              busy_ld_s  = 1'b1;
              mode4_nx_s = 1'b1;
              state_nx_s = ST_HI;
            end else begin
              err_nx_s = 1'b1;
            end
          end
          ST_HI: begin
            hi_nib_nx_s = tap_dat_s;
            hi_rs_nx_s  = tap_rs_s;
            state_nx_s  = ST_LO;
          end
          ST_LO: begin
            state_nx_s   = ST_HI;
            vld_nx_s     = 1'b1;
            byte_nx_s    = asm_byte_s;
            byte_rs_nx_s = tap_rs_s;
            busy_ld_s    = 1'b1;
            if (tap_rs_s != hi_rs_r) begin
              err_nx_s = 1'b1;
            end else begin
              err_nx_s = err_r;
            end
            if (tap_rs_s) begin
              mem_we_s = 1'b1;
              ac_nx_s  = ac_inc(ac_r);
            end else if (asm_byte_s == 8'h01) begin
              mem_clr_s  = 1'b1;
              ac_nx_s    = 7'h00;
              busy_val_s = CLEAR_LD;
            end else if (asm_byte_s[7:1] == 7'h01) begin
              ac_nx_s = 7'h00;
            end else if (asm_byte_s[7]) begin
              // Only 0x00-0x0F and 0x40-0x4F are real display addresses.
              if (asm_byte_s[5:4] == 2'b00) begin
                ac_nx_s = asm_byte_s[6:0];
              end else begin
                err_nx_s = 1'b1;
              end
            end else begin
              ac_nx_s = ac_r;
            end
          end
          default: begin
            state_nx_s = ST_INIT8;
          end
        endcase
      end
    end else if (rd_stb_s && mode4_r) begin
      rd_lo_nx_s = ~rd_lo_r;
      if (!tap_rs_s) begin
        q_nx_s = rd_lo_r ? ac_r[3:0] : {busy_r, ac_r[6:4]};
      end else if (rd_lo_r) begin
        q_nx_s  = cur_char_s[3:0];
        ac_nx_s = ac_inc(ac_r);
      end else begin
        q_nx_s = cur_char_s[7:4];
      end
    end else begin
      rd_lo_nx_s = rd_lo_r;
    end
  end

  // Busy countdown: reload on execute, otherwise count down to zero.
  always_comb begin
    if (busy_ld_s) begin
      cnt_nx_s = busy_val_s;
    end else if (cnt_r != '0) begin
      cnt_nx_s = cnt_r - CW'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Control/status registers and registered outputs.
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r   <= ST_INIT8;
      mode4_r   <= 1'b0;
      err_r     <= 1'b0;
      ac_r      <= 7'h00;
      hi_nib_r  <= 4'h0;
      hi_rs_r   <= 1'b0;
      rd_lo_r   <= 1'b0;
      q_r       <= 4'h0;
      vld_r     <= 1'b0;
      byte_r    <= 8'h00;
      byte_rs_r <= 1'b0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      mode4_r   <= mode4_nx_s;
      err_r     <= err_nx_s;
      ac_r      <= ac_nx_s;
      hi_nib_r  <= hi_nib_nx_s;
      hi_rs_r   <= hi_rs_nx_s;
      rd_lo_r   <= rd_lo_nx_s;
      q_r       <= q_nx_s;
      vld_r     <= vld_nx_s;
      byte_r    <= byte_nx_s;
      byte_rs_r <= byte_rs_nx_s;
      cnt_r     <= cnt_nx_s;
      busy_r    <= (cnt_nx_s != '0);
    end
  end

  // Display buffer: reset and clear fill with spaces, data bytes land at the cursor.
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= 8'h20;
      end
    end else if (mem_clr_s) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= 8'h20;
      end
    end else if (mem_we_s) begin
      mem_r[idx_s] <= asm_byte_s;
    end
  end

  assign LCDQ     = q_r;
  assign MODE4    = mode4_r;
  assign BUSY     = busy_r;
  assign ERR      = err_r;
  assign BYTE_VLD = vld_r;
  assign BYTE     = byte_r;
  assign BYTE_RS  = byte_rs_r;
  assign RD_CHAR  = mem_r[RD_IDX];

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Bench for lcd_nibble_receiver: directed scenarios plus random traffic.
// A behavioural LCD model tracks the cursor as a 0..31 position, the display as a byte array
// and busy as an absolute end cycle.
module tb_lcd_nibble_receiver;
  logic       CCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       LCDE = 1'b0;
  logic       LCDRS = 1'b0;
  logic       LCDRW = 1'b0;
  logic [3:0] LCDDAT = 4'h0;
  logic [4:0] RD_IDX = 5'd0;
  logic [3:0] LCDQ;
  logic       MODE4, BUSY, ERR, BYTE_VLD, BYTE_RS;
  logic [7:0] BYTE, RD_CHAR;

  localparam int BC = 40;
  localparam int CC = 1600;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  bit         m_mode4, m_have_hi, m_hi_rs, m_err, m_rd_lo;
  logic [3:0] m_hi, m_q;
  int         m_pos;
  logic [7:0] m_mem [32];
  int         busy_until;
  bit         exp_vld, exp_rs;
  logic [7:0] exp_byte;
  logic [7:0] rd_before;

  lcd_nibble_receiver #(.SYNC_STAGES(2), .BUSY_CYC(BC), .CLEAR_CYC(CC)) dut (
    .CCLK(CCLK), .RSTN(RSTN), .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDDAT(LCDDAT),
    .LCDQ(LCDQ), .MODE4(MODE4), .BUSY(BUSY), .ERR(ERR), .BYTE_VLD(BYTE_VLD),
    .BYTE_RS(BYTE_RS), .BYTE(BYTE), .RD_IDX(RD_IDX), .RD_CHAR(RD_CHAR)
  );

  always #5 CCLK = ~CCLK;

  // free-running cycle count used as the model's time base
  always @(posedge CCLK) cyc <= cyc + 1;

  function automatic logic [6:0] ac_of(input int p);
    return (p < 16) ? 7'(p) : 7'(p + 48);
  endfunction

  task automatic model_reset();
    m_mode4 = 0; m_have_hi = 0; m_hi_rs = 0; m_err = 0; m_rd_lo = 0;
    m_hi = 4'h0; m_q = 4'h0; m_pos = 0; busy_until = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
  endtask

  task automatic model_exec(input bit rs, input logic [7:0] b, input int t);
    int a;
    if (rs) begin
      m_mem[m_pos] = b;
      m_pos = (m_pos + 1) % 32;
      busy_until = t + BC;
    end else if (b == 8'h01) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_pos = 0;
      busy_until = t + CC;
    end else begin
      busy_until = t + BC;
      a = int'(b) - 128;
      if (b == 8'h02 || b == 8'h03) m_pos = 0;
      else if (a >= 0 && a < 16) m_pos = a;
      else if (a >= 64 && a < 80) m_pos = a - 48;
      else if (a >= 0) m_err = 1;
    end
  endtask

  task automatic model_write(input bit rs, input logic [3:0] dat, input int d, input bit bsy);
    if (bsy) m_err = 1;
    else if (!m_mode4) begin
      if (dat == 4'h3) busy_until = d + 3 + BC;
      else if (dat == 4'h2 && !rs) begin m_mode4 = 1; m_have_hi = 0; busy_until = d + 3 + BC; end
      else m_err = 1;
    end else if (!m_have_hi) begin
      m_have_hi = 1; m_hi = dat; m_hi_rs = rs;
    end else begin
      m_have_hi = 0;
      exp_vld = 1; exp_byte = {m_hi, dat}; exp_rs = rs;
      if (rs != m_hi_rs) m_err = 1;
      model_exec(rs, {m_hi, dat}, d + 3);
    end
  endtask

  task automatic model_read(input bit rs, input bit bsy);
    logic [6:0] ac;
    logic [7:0] ch;
    if (m_mode4) begin
      ac = ac_of(m_pos);
      ch = m_mem[m_pos];
      if (!rs) m_q = m_rd_lo ? ac[3:0] : {bsy, ac[6:4]};
      else begin
        m_q = m_rd_lo ? ch[3:0] : ch[7:4];
        if (m_rd_lo) m_pos = (m_pos + 1) % 32;
      end
      m_rd_lo = !m_rd_lo;
    end
  endtask

  // one E pulse; compares all status outputs at the capture cycle
  task automatic strobe(input bit rs, input bit rw, input logic [3:0] dat);
    int d;
    bit bsy;
    @(negedge CCLK);
    LCDRS = rs; LCDRW = rw; LCDDAT = dat; LCDE = 1'b1;
    repeat (2) @(negedge CCLK);
    LCDE = 1'b0;
    d = cyc;
    bsy = (d + 2 < busy_until);
    exp_vld = 0;
    if (!rw) model_write(rs, dat, d, bsy);
    else model_read(rs, bsy);
    repeat (2) @(negedge CCLK);
    rd_before = RD_CHAR;
    @(negedge CCLK);
    total++;
    if (BYTE_VLD !== exp_vld) begin bad++; $display("FAIL byte_vld: got %b want %b", BYTE_VLD, exp_vld); end
    if (exp_vld) begin
      total++;
      if ({BYTE_RS, BYTE} !== {exp_rs, exp_byte})
        begin bad++; $display("FAIL byte: got %b/%h want %b/%h", BYTE_RS, BYTE, exp_rs, exp_byte); end
    end
    total++;
    if (ERR !== m_err) begin bad++; $display("FAIL err: got %b want %b", ERR, m_err); end
    total++;
    if (MODE4 !== m_mode4) begin bad++; $display("FAIL mode4: got %b want %b", MODE4, m_mode4); end
    total++;
    if (BUSY !== (cyc < busy_until)) begin bad++; $display("FAIL busy: got %b want %b", BUSY, cyc < busy_until); end
    total++;
    if (LCDQ !== m_q) begin bad++; $display("FAIL lcdq: got %h want %h", LCDQ, m_q); end
  endtask

  // waits for BUSY low and checks it drops on the exact modelled cycle
  task automatic wait_idle();
    int n;
    int exp_c;
    n = 0;
    exp_c = (busy_until > cyc) ? busy_until : cyc;
    while (BUSY === 1'b1 && n < 3000) begin @(negedge CCLK); n++; end
    total++;
    if (BUSY !== 1'b0 || cyc != exp_c)
      begin bad++; $display("FAIL busy_end: got cycle %0d busy=%b want cycle %0d", cyc, BUSY, exp_c); end
  endtask

  task automatic write_byte(input bit rs, input logic [7:0] b);
    wait_idle();
    strobe(rs, 1'b0, b[7:4]);
    strobe(rs, 1'b0, b[3:0]);
  endtask

  task automatic read_pair(input bit rs, output logic [7:0] q);
    strobe(rs, 1'b1, 4'h0);
    q[7:4] = LCDQ;
    strobe(rs, 1'b1, 4'h0);
    q[3:0] = LCDQ;
  endtask

  task automatic check_mem();
    for (int i = 0; i < 32; i++) begin
      RD_IDX = 5'(i);
      #1;
      total++;
      if (RD_CHAR !== m_mem[i]) begin bad++; $display("FAIL rd_char[%0d]: got %h want %h", i, RD_CHAR, m_mem[i]); end
    end
  endtask

  task automatic check_char(input int i, input logic [7:0] want);
    RD_IDX = 5'(i);
    #1;
    total++;
    if (RD_CHAR !== want) begin bad++; $display("FAIL plan_char[%0d]: got %h want %h", i, RD_CHAR, want); end
  endtask

  task automatic check_ac(input logic [7:0] want);
    logic [7:0] q;
    read_pair(1'b0, q);
    total++;
    if (q !== want) begin bad++; $display("FAIL plan_ac: got %h want %h", q, want); end
  endtask

  task automatic do_reset();
    @(negedge CCLK);
    RSTN = 1'b0; LCDE = 1'b0;
    #1;
    total++;
    if ({LCDQ, MODE4, BUSY, ERR, BYTE_VLD, BYTE_RS, BYTE} !== 19'h0)
      begin bad++; $display("FAIL reset_out: got %h want 0", {LCDQ, MODE4, BUSY, ERR, BYTE_VLD, BYTE_RS, BYTE}); end
    model_reset();
    @(negedge CCLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    check_mem();
  endtask

  task automatic test_init();
    strobe(1'b0, 1'b0, 4'h3); wait_idle();
    strobe(1'b0, 1'b0, 4'h3); wait_idle();
    strobe(1'b0, 1'b0, 4'h3); wait_idle();
    strobe(1'b0, 1'b0, 4'h2);
    total++;
    if (MODE4 !== 1'b1 || ERR !== 1'b0) begin bad++; $display("FAIL plan_init: got mode4=%b err=%b want 1/0", MODE4, ERR); end
    wait_idle();
  endtask

  task automatic test_write_hi();
    write_byte(1'b0, 8'h80);
    write_byte(1'b1, 8'h48);
    write_byte(1'b1, 8'h69);
    check_char(0, 8'h48);
    check_char(1, 8'h69);
    wait_idle();
    check_ac(8'h02);
  endtask

  task automatic test_wrap();
    write_byte(1'b0, 8'h8F);
    write_byte(1'b1, 8'h41);
    write_byte(1'b1, 8'h42);
    check_char(15, 8'h41);
    check_char(16, 8'h42);
    wait_idle();
    check_ac(8'h41);
    write_byte(1'b0, 8'hCF);
    write_byte(1'b1, 8'h43);
    check_char(31, 8'h43);
    wait_idle();
    check_ac(8'h00);
  endtask

  task automatic test_clear();
    RD_IDX = 5'd0;
    write_byte(1'b0, 8'h01);
    total++;
    if (rd_before !== 8'h48 || RD_CHAR !== 8'h20)
      begin bad++; $display("FAIL clear_edge: got %h->%h want 48->20", rd_before, RD_CHAR); end
    repeat (10) @(negedge CCLK);
    strobe(1'b1, 1'b0, 4'h5);
    total++;
    if (ERR !== 1'b1) begin bad++; $display("FAIL plan_busy_err: got %b want 1", ERR); end
    check_mem();
  endtask

  task automatic test_busy_read();
    check_ac(8'h80);
    wait_idle();
    write_byte(1'b0, 8'hC5);
    wait_idle();
    check_ac(8'h45);
  endtask

  task automatic test_random();
    logic [7:0] q;
    int op;
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: write_byte(1'b1, 8'($urandom_range(32, 126)));
        4: write_byte(1'b0, 8'h80 | 8'($urandom_range(0, 1) * 64 + $urandom_range(0, 15)));
        5: write_byte(1'b0, 8'h80 | 8'($urandom_range(0, 127)));
        6: write_byte(1'b0, 8'($urandom_range(2, 3)));
        7: write_byte(1'b0, 8'($urandom_range(4, 127)));
        8: read_pair(1'b0, q);
        default: read_pair(1'b1, q);
      endcase
    end
    wait_idle();
    check_mem();
  endtask

  task automatic test_reset_midbyte();
    wait_idle();
    strobe(1'b1, 1'b0, 4'h4);
    do_reset();
    check_mem();
    strobe(1'b0, 1'b0, 4'h2);
    wait_idle();
    write_byte(1'b1, 8'h5A);
    check_char(0, 8'h5A);
  endtask

  task automatic test_bad_addr();
    write_byte(1'b0, 8'h95);
    total++;
    if (ERR !== 1'b1) begin bad++; $display("FAIL plan_bad_addr: got %b want 1", ERR); end
    wait_idle();
    check_ac(8'h01);
  endtask

  task automatic test_rs_mismatch();
    do_reset();
    strobe(1'b0, 1'b0, 4'h2);
    wait_idle();
    strobe(1'b0, 1'b0, 4'h6);
    strobe(1'b1, 1'b0, 4'h1);
    check_char(0, 8'h61);
    wait_idle();
  endtask

  task automatic test_init_err();
    do_reset();
    strobe(1'b0, 1'b0, 4'h5);
    strobe(1'b1, 1'b0, 4'h2);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init();
    test_write_hi();
    test_wrap();
    test_clear();
    test_busy_read();
    test_random();
    test_reset_midbyte();
    test_bad_addr();
    test_rs_mismatch();
    test_init_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_nibble_receiver.md
Name: lcd_nibble_receiver

Overview:
- Receiving end of the 4-bit character-LCD bus (LCDE/LCDRS/LCDRW/LCDDAT) that the pipeline top level drives.
- Samples strobes and reassembles the 4-bit init sequence and nibble pairs into command and data bytes.
- Executes the command subset the pipeline uses and keeps a 32-character display buffer (2 lines x 16).
- Generates busy timing and a read-back nibble, so simulation and on-board checks can see what the LCD would show.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on LCDE/LCDRS/LCDRW/LCDDAT (min 2).
- BUSY_CYC, 40, CCLK cycles busy after each executed byte or init nibble.
- CLEAR_CYC, 1600, CCLK cycles busy after clear-display (0x01).

Ports:
- CCLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- LCDE  in  1  enable strobe from writer; captured on falling edge.
- LCDRS  in  1  0 = command, 1 = data.
- LCDRW  in  1  0 = write, 1 = read.
- LCDDAT  in  4  nibble from writer.
- LCDQ  out  4  read-back nibble, valid while LCDRW=1.
- MODE4  out  1  1 once 4-bit mode is established.
- BUSY  out  1  busy flag.
- ERR  out  1  sticky protocol error.
- BYTE_VLD  out  1  one-cycle pulse per assembled write byte.
- BYTE_RS  out  1  RS of that byte.
- BYTE  out  8  assembled byte.
- RD_IDX  in  5  buffer read index (0-15 line 0, 16-31 line 1).
- RD_CHAR  out  8  buffer[RD_IDX], combinational.

Behaviour:
- Reset (async assert, sync release):
  - MODE4=0, BUSY=0, ERR=0, BYTE_VLD=0, BYTE=0, BYTE_RS=0, LCDQ=0.
  - Address counter AC=0, nibble phase=HI.
  - All 32 buffer entries = 0x20.
- Strobe capture:
  - All four inputs pass through SYNC_STAGES flops.
  - A strobe is synced E = 1 then 0 on consecutive cycles.
  - RS, RW and DAT are taken from the same synced stage as the E=1 sample.
  - Strobe-to-BYTE_VLD latency = SYNC_STAGES + 1 cycles after the falling E edge.
- States: INIT8, HI, LO.
  - INIT8, after reset: each RW=0 strobe is a lone upper nibble.
    - 0x3: BUSY for BUSY_CYC, stay in INIT8.
    - 0x2 with RS=0: MODE4=1, go to HI.
    - Anything else: ERR=1, stay in INIT8.
  - HI: latch nibble into BYTE[7:4], go to LO.
  - LO: form the byte, pulse BYTE_VLD, execute the byte, go to HI.
  - An RS change between HI and LO: ERR=1, byte still executed using the LO-phase RS.
- Execute, RS=0:
  - 0x01: all 32 entries = 0x20, AC=0, BUSY for CLEAR_CYC.
  - 0x02/0x03: AC=0.
  - 0x80|a: AC=a for a in 0x00-0x0F or 0x40-0x4F; any other a sets ERR=1 and leaves AC unchanged.
  - Any other command is accepted with no effect.
  - Every command not listed above with its own busy time: BUSY for BUSY_CYC.
- Execute, RS=1:
  - buffer[idx(AC)] = byte, where idx = AC[3:0] + 16*AC[6].
  - AC increments. Wrap: 0x0F -> 0x40, 0x4F -> 0x00.
  - BUSY for BUSY_CYC.
- Busy counter:
  - Loaded on the execute cycle; BUSY=1 while the count is nonzero.
  - A write strobe captured while BUSY=1 sets ERR=1 and is otherwise ignored: nibble phase does not advance, no BYTE_VLD.
- Read (RW=1 strobe, MODE4=1):
  - RS=0, HI phase: LCDQ = {BUSY, AC[6:4]}.
  - RS=0, LO phase: LCDQ = AC[3:0].
  - The phase toggles on each read strobe and is kept separate from the write phase.
  - LCDQ is updated at capture and holds until the next read strobe.
  - RS=1 reads: LCDQ = nibble of buffer[idx(AC)]; AC increments after the LO nibble.
  - Reads are legal while BUSY=1.
- ERR clears only on reset.
- Reset mid-byte: the half byte is discarded and the state returns to INIT8.
- Simultaneous clear-display and RD_IDX read: RD_CHAR shows the old value that cycle and 0x20 from the next cycle.

Test Plan:
1. Init sequence: RSTN low then high; nibbles 0x3, 0x3, 0x3, 0x2 (RS=0), each followed by the BUSY wait.
   -> MODE4=1 after the 4th strobe, ERR=0, BUSY high for 40 cycles after each strobe.
2. After init: write 0x80 (cmd), then 'H' (0x48) and 'i' (0x69) (data).
   -> BYTE_VLD pulses with BYTE=0x80/0x48/0x69, RD_CHAR[0]=0x48, RD_CHAR[1]=0x69, AC=0x02.
3. Line wrap: cmd 0x8F, then data 0x41, 0x42.
   -> RD_CHAR[15]=0x41, RD_CHAR[16]=0x42, AC=0x41.
   Then cmd 0xCF, data 0x43 -> RD_CHAR[31]=0x43, AC=0x00.
4. Clear: cmd 0x01.
   -> BUSY=1 for 1600 cycles, all RD_CHAR=0x20.
   A strobe issued 10 cycles after the clear -> ERR=1, buffer unchanged.
5. Busy read: during BUSY, two RW=1 RS=0 strobes.
   -> LCDQ=0x8 (BUSY=1, AC=0x00) then 0x0.
   After BUSY drops, cmd 0xC5 and reads -> LCDQ=0x4 then 0x5.
6. Reset mid-byte: HI nibble 0x4, then RSTN pulse low.
   -> outputs at reset values immediately, MODE4=0.
   A following 0x2 nibble re-enters 4-bit mode with no spurious BYTE_VLD.
